servo_angle_scheduler: RTL and testbench

Time-multiplexed servo frame controller for the robotic manipulator: it holds one target angle per joint and slews each joint's current angle toward its target by a bounded step once per servo frame. It shares a single external angle-to-cycles mapper across all joints and generates every joint's PWM pulse from a common frame counter. It sits between the command/decode logic and the servo pins, and is the only user of the mapper.

---
 rtl/servo_angle_scheduler.sv | 167 ++++++++++++++++
 tb/tb_servo_angle_scheduler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/servo_angle_scheduler.sv
// Servo frame controller: slews each joint toward its target once per frame through a
// shared angle-to-cycles mapper and drives registered PWM pulses from one frame counter.
module servo_angle_scheduler #(
    parameter int N_JOINTS     = 4,
    parameter int FRAME_CYCLES = 1000000,
    parameter int STEP_DEG     = 2,
    parameter int MAX_DEG      = 180,
    parameter int RESET_CYCLES = 25000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_joint,
    input  logic [15:0]         cmd_angle,
    output logic                cmd_err,
    output logic [15:0]         map_angle,
    input  logic [24:0]         map_cycles,
    output logic [N_JOINTS-1:0] pwm,
    output logic                busy,
    output logic                frame_done
);

    localparam int                JW         = (N_JOINTS > 1) ? $clog2(N_JOINTS) : 1;
    localparam logic [24:0]       FRAME_LAST = 25'(FRAME_CYCLES - 1);
    localparam logic [24:0]       RESET_W    = 25'(RESET_CYCLES);
    localparam logic [15:0]       MAX_A      = 16'(MAX_DEG);
    localparam logic [15:0]       STEP_U     = 16'(STEP_DEG);
    localparam logic signed [16:0] STEP_S    = 17'(STEP_DEG);
    localparam logic [JW-1:0]     J_LAST     = JW'(N_JOINTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SLEW, S_LATCH, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [JW-1:0]       j_q, j_d;
    logic [24:0]         cnt_q;
    logic [15:0]         cur_q    [N_JOINTS];
    logic [15:0]         target_q [N_JOINTS];
    logic [24:0]         shadow_q [N_JOINTS];
    logic [24:0]         active_q [N_JOINTS];
    logic [15:0]         map_angle_q;
    logic [N_JOINTS-1:0] pwm_q;
    logic                cmd_err_q;

    logic                cmd_fire_s;
    logic [15:0]         clamp_s;
    logic                bad_cmd_s;
    logic signed [16:0]  diff_s;
    logic [15:0]         cur_next_s;

    assign cmd_ready  = ~rst;
    assign cmd_fire_s = cmd_valid && cmd_ready;
    assign cmd_err    = cmd_err_q;
    assign map_angle  = map_angle_q;
    assign pwm        = pwm_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);

    // Frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 25'd0;
        end else if (cnt_q == FRAME_LAST) begin
            cnt_q <= 25'd0;
        end else begin
            cnt_q <= cnt_q + 25'd1;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
        end
    end

    // Sequencer next state
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        case (state_q)
            S_IDLE: begin
                if (cnt_q == 25'd0) state_d = S_SLEW;
                else                state_d = S_IDLE;
            end
            S_SLEW:  state_d = S_LATCH;
            S_LATCH: begin
                if (j_q == J_LAST) begin
                    state_d = S_DONE;
                    j_d     = '0;
                end else begin
                    state_d = S_SLEW;
                    j_d     = j_q + JW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bounded slew step; 17-bit signed difference cannot wrap
    always_comb begin
        diff_s = $signed({1'b0, target_q[j_q]}) - $signed({1'b0, cur_q[j_q]});
        if (diff_s > STEP_S) begin
            cur_next_s = cur_q[j_q] + STEP_U;
        end else if (diff_s < -STEP_S) begin
            cur_next_s = cur_q[j_q] - STEP_U;
        end else begin
            cur_next_s = target_q[j_q];
        end
    end

    // Command checks
    always_comb begin
        if (cmd_angle > MAX_A) clamp_s = MAX_A;
        else                   clamp_s = cmd_angle;
        bad_cmd_s = (cmd_angle > MAX_A) || (int'(cmd_joint) >= N_JOINTS);
    end

    // Target table and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_JOINTS; k++) target_q[k] <= 16'd0;
            cmd_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < N_JOINTS; k++) begin
                if (cmd_fire_s && (int'(cmd_joint) == k)) target_q[k] <= clamp_s;
            end
            cmd_err_q <= cmd_fire_s && bad_cmd_s;
        end
    end

    // Current angles, mapper input and shadow widths
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_JOINTS; k++) begin
                cur_q[k]    <= 16'd0;
                shadow_q[k] <= RESET_W;
            end
            map_angle_q <= 16'd0;
        end else begin
            if (state_q == S_SLEW) begin
                cur_q[j_q]  <= cur_next_s;
                map_angle_q <= cur_next_s;
            end
            if (state_q == S_LATCH) shadow_q[j_q] <= map_cycles;
        end
    end

    // Atomic shadow-to-active load at frame end, and pulse generation
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_JOINTS; k++) active_q[k] <= RESET_W;
            pwm_q <= '0;
        end else begin
            if (cnt_q == FRAME_LAST) begin
                for (int k = 0; k < N_JOINTS; k++) active_q[k] <= shadow_q[k];
            end
            for (int k = 0; k < N_JOINTS; k++) pwm_q[k] <= (cnt_q < active_q[k]);
        end
    end

endmodule

// File: tb/tb_servo_angle_scheduler.sv
// Directed plus random stimulus against a frame-level model of slew, mapping and pulse widths.
module tb_servo_angle_scheduler;

    localparam int NJ   = 4;
    localparam int FC   = 400;
    localparam int STEP = 2;
    localparam int MAXD = 180;
    localparam int RC   = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_joint = 3'd0;
    logic [15:0]   cmd_angle = 16'd0;
    logic          cmd_err;
    logic [15:0]   map_angle;
    logic [24:0]   map_cycles;
    logic [NJ-1:0] pwm;
    logic          busy;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cur [NJ];
    int m_tgt [NJ];
    int m_act [NJ];
    int m_shd [NJ];

    servo_angle_scheduler #(
        .N_JOINTS(NJ), .FRAME_CYCLES(FC), .STEP_DEG(STEP), .MAX_DEG(MAXD), .RESET_CYCLES(RC)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_joint(cmd_joint), .cmd_angle(cmd_angle), .cmd_err(cmd_err),
        .map_angle(map_angle), .map_cycles(map_cycles), .pwm(pwm),
        .busy(busy), .frame_done(frame_done)
    );

    function automatic int map_model(input int a);
        return 50 + 2 * a;
    endfunction

    // Scaled mapper: 180 degrees maps past the frame length to exercise the full-high case
    assign map_cycles = 25'(map_model(int'(map_angle)));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < NJ; j++) begin
            m_cur[j] = 0;
            m_tgt[j] = 0;
            m_act[j] = RC;
            m_shd[j] = RC;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_map_angle", 32'(map_angle), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
        model_reset();
    endtask

    // Runs ncyc cycles of one frame; a full frame checks widths, busy, done and error pulses
    task automatic run_frame(input int ncyc, input bit do_cmd, input int cj, input int ca);
        int hi [NJ];
        int nbusy;
        int ndone;
        int nerr;
        int exp_err;
        int d;
        nbusy = 0;
        ndone = 0;
        nerr  = 0;
        for (int j = 0; j < NJ; j++) begin
            hi[j] = 0;
            d = m_tgt[j] - m_cur[j];
            if (d > STEP)       m_cur[j] = m_cur[j] + STEP;
            else if (d < -STEP) m_cur[j] = m_cur[j] - STEP;
            else                m_cur[j] = m_tgt[j];
            m_shd[j] = map_model(m_cur[j]);
        end
        exp_err = (do_cmd && (ca > MAXD || cj >= NJ)) ? 1 : 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            for (int j = 0; j < NJ; j++) hi[j] += int'(pwm[j]);
            nbusy += int'(busy);
            ndone += int'(frame_done);
            nerr  += int'(cmd_err);
            if ((i % 2 == 1) && (i < 2 * NJ))
                check($sformatf("map_angle_j%0d", i / 2), 32'(map_angle), 32'(m_cur[i / 2]));
            if (do_cmd && i == 100) begin
                cmd_valid = 1'b1;
                cmd_joint = 3'(cj);
                cmd_angle = 16'(ca);
            end
            if (i == 101) cmd_valid = 1'b0;
        end
        if (ncyc == FC) begin
            for (int j = 0; j < NJ; j++)
                check($sformatf("pwm_width_j%0d", j), 32'(hi[j]), 32'((m_act[j] < FC) ? m_act[j] : FC));
            check("busy_cycles", 32'(nbusy), 32'(2 * NJ + 1));
            check("frame_done_pulses", 32'(ndone), 32'd1);
            check("cmd_err_pulses", 32'(nerr), 32'(exp_err));
            for (int j = 0; j < NJ; j++) m_act[j] = m_shd[j];
            if (do_cmd && cj < NJ) m_tgt[cj] = (ca > MAXD) ? MAXD : ca;
        end
    endtask

    initial begin
        model_reset();
        do_reset();
        repeat (3) run_frame(FC, 1'b0, 0, 0);

        run_frame(FC, 1'b1, 1, 10);
        repeat (7) run_frame(FC, 1'b0, 0, 0);

        run_frame(FC, 1'b1, 0, 250);
        repeat (92) run_frame(FC, 1'b0, 0, 0);

        run_frame(FC, 1'b1, 5, 30);
        repeat (2) run_frame(FC, 1'b0, 0, 0);

        run_frame(FC, 1'b1, 2, 20);
        repeat (2) run_frame(FC, 1'b0, 0, 0);
        run_frame(FC, 1'b1, 2, 0);
        repeat (5) run_frame(FC, 1'b0, 0, 0);

        // Reset lands while joint 2 is in LATCH
        run_frame(6, 1'b0, 0, 0);
        do_reset();
        repeat (2) run_frame(FC, 1'b0, 0, 0);

        repeat (12) run_frame(FC, 1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 260)));
        repeat (3) run_frame(FC, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
